mem_port_arbiter: RTL and testbench

//  Shares one single-port byte-addressed memory between instruction fetch (IF) and the
//  MEM pipeline stage (load/store). Arbitrates requests with a req/gnt handshake and

---
 rtl/mem_port_arbiter_if.sv | 55 +++++
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_port_arbiter_if                                          |
// | Description : Bundles the IF requester, MEM requester and single-port      |
// |               memory signals shared by mem_port_arbiter and its            |
// |               environment.                                                 |
// |               slave  : arbiter side (takes requests, drives memory)        |
// |               master : environment side (requesters + memory model)        |
// | Signals     : if_req/if_addr/if_gnt/if_rvalid/if_rdata      IF port        |
// |               mem_req/mem_we/mem_addr/mem_wdata/mem_gnt/                   |
// |               mem_rvalid/mem_rdata                          MEM port       |
// |               m_addr/m_wdata/m_re/m_we/m_rdata              memory         |
// |               misalign/busy                                 status         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;

    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_re;
    logic          m_we;
    logic [DW-1:0] m_rdata;

    logic          misalign;
    logic          busy;

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, m_rdata,
        output if_gnt, if_rvalid, if_rdata, mem_gnt, mem_rvalid, mem_rdata,
               m_addr, m_wdata, m_re, m_we, misalign, busy
    );

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, m_rdata,
        input  if_gnt, if_rvalid, if_rdata, mem_gnt, mem_rvalid, mem_rdata,
               m_addr, m_wdata, m_re, m_we, misalign, busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_port_arbiter                                             |
// | Description : Shares one single-port, byte-addressed, big-endian memory    |
// |               (registered 1-cycle read, posedge write) between IF fetch    |
// |               and the MEM stage. One access at a time:                     |
// |               IDLE -> ISSUE -> IDLE (store) / WAIT -> RESP -> IDLE (load). |
// | Ports       : clk    - clock, posedge                                      |
// |               rst_n  - asynchronous, active-low reset                      |
// |               bus    - mem_port_arbiter_if.slave (requests, memory, status)|
// | Options     : ARB_ROUND_ROBIN_EN - alternate winner on simultaneous        |
// |               requests; undefined gives fixed priority MEM > IF.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t        r_state;
    logic          r_owner_mem;
    logic          r_we;
    logic          r_mis;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_mem_rdata;
    logic          r_m_re;
    logic          r_m_we;
    logic          r_misalign;
    logic          r_if_rvalid;
    logic          r_mem_rvalid;

    logic          w_pick_mem;
    logic          w_grant;
    logic [AW-1:0] w_addr;
    logic          w_we;
    logic          w_mis;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = MEM was granted last; a tie goes to the other requester.
    logic          r_last_mem;
    assign w_pick_mem = bus.mem_req & (~bus.if_req | ~r_last_mem);
`else
    assign w_pick_mem = bus.mem_req;
`endif

    assign w_grant = (r_state == S_IDLE) & (bus.mem_req | bus.if_req);
    assign w_addr  = w_pick_mem ? bus.mem_addr : bus.if_addr;
    // IF is read-only, so only a MEM winner can produce a store.
    assign w_we    = w_pick_mem & bus.mem_we;
    assign w_mis   = |w_addr[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_owner_mem  <= 1'b0;
            r_we         <= 1'b0;
            r_mis        <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_if_rdata   <= '0;
            r_mem_rdata  <= '0;
            r_m_re       <= 1'b0;
            r_m_we       <= 1'b0;
            r_misalign   <= 1'b0;
            r_if_rvalid  <= 1'b0;
            r_mem_rvalid <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_mem   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_owner_mem <= w_pick_mem;
                        r_we        <= w_we;
                        r_mis       <= w_mis;
                        r_addr      <= w_addr;
                        if (w_pick_mem) begin
                            r_wdata <= bus.mem_wdata;
                        end
                        // Enables are pre-computed here so they are register
                        // outputs during exactly the ISSUE cycle. A misaligned
                        // access never touches the memory.
                        r_m_re      <= ~w_we & ~w_mis;
                        r_m_we      <= w_we & ~w_mis;
                        r_misalign  <= w_mis;
`ifdef ARB_ROUND_ROBIN_EN
                        r_last_mem  <= w_pick_mem;
`endif
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_m_re     <= 1'b0;
                    r_m_we     <= 1'b0;
                    r_misalign <= 1'b0;
                    r_state    <= r_we ? S_IDLE : S_WAIT;
                end
                S_WAIT: begin
                    // Memory data from the ISSUE read is valid this cycle.
                    if (r_owner_mem) begin
                        r_mem_rdata  <= r_mis ? '0 : bus.m_rdata;
                        r_mem_rvalid <= 1'b1;
                    end else begin
                        r_if_rdata   <= r_mis ? '0 : bus.m_rdata;
                        r_if_rvalid  <= 1'b1;
                    end
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    r_if_rvalid  <= 1'b0;
                    r_mem_rvalid <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.if_gnt     = w_grant & ~w_pick_mem;
    assign bus.mem_gnt    = w_grant & w_pick_mem;
    assign bus.if_rvalid  = r_if_rvalid;
    assign bus.if_rdata   = r_if_rdata;
    assign bus.mem_rvalid = r_mem_rvalid;
    assign bus.mem_rdata  = r_mem_rdata;
    assign bus.m_addr     = r_addr;
    assign bus.m_wdata    = r_wdata;
    assign bus.m_re       = r_m_re;
    assign bus.m_we       = r_m_we;
    assign bus.misalign   = r_misalign;
    assign bus.busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_port_arbiter                                          |
// | Description : Self-checking bench for mem_port_arbiter. A transaction-     |
// |               level reference (grant rule, free-at cycle, byte memory)     |
// |               predicts every output each cycle. Includes a byte memory     |
// |               responder with a registered 1-cycle read.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Memory responder (the physical memory) and the reference copy.
    logic [7:0] mem     [0:255];
    logic [7:0] ref_mem [0:255];

    always @(posedge clk) begin
        logic [7:0] a;
        a = bus.m_addr[7:0];
        if (bus.m_we) begin
            mem[a]        <= bus.m_wdata[31:24];
            mem[a + 8'd1] <= bus.m_wdata[23:16];
            mem[a + 8'd2] <= bus.m_wdata[15:8];
            mem[a + 8'd3] <= bus.m_wdata[7:0];
        end
        if (bus.m_re) begin
            bus.m_rdata <= {mem[a], mem[a + 8'd1], mem[a + 8'd2], mem[a + 8'd3]};
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int          cyc = 0;
    int          free_at = 0;     // first cycle a new grant is possible
    bit          txn_v = 1'b0;
    int          tg = 0;          // grant cycle of current access
    bit          t_mem, t_we, t_mis;
    logic [31:0] t_addr, t_wdata, t_data;
    bit          last_mem = 1'b0;
    logic [31:0] exp_if_rdata = '0, exp_mem_rdata = '0, exp_m_addr = '0;

    function automatic logic [31:0] ref_word(input logic [7:0] a);
        return {ref_mem[a], ref_mem[a + 8'd1], ref_mem[a + 8'd2], ref_mem[a + 8'd3]};
    endfunction

    // One clock cycle: predict and compare at negedge, step model, advance
    // past posedge and drop any request that was just accepted.
    task automatic cycle();
        bit e_if_g, e_mem_g, in_issue, in_resp;
        @(negedge clk);
        e_if_g  = 1'b0;
        e_mem_g = 1'b0;
        if (cyc >= free_at) begin
            if (bus.mem_req && bus.if_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                if (last_mem) e_if_g = 1'b1; else e_mem_g = 1'b1;
`else
                e_mem_g = 1'b1;
`endif
            end else if (bus.mem_req) begin
                e_mem_g = 1'b1;
            end else if (bus.if_req) begin
                e_if_g = 1'b1;
            end
        end
        in_issue = txn_v && (cyc == tg + 1);
        in_resp  = txn_v && (cyc == tg + 3) && !t_we;

        if (in_issue) begin
            if (t_we && !t_mis) begin
                for (int k = 0; k < 4; k++)
                    ref_mem[t_addr[7:0] + 8'(k)] = t_wdata[31 - 8*k -: 8];
            end
            if (!t_we) t_data = t_mis ? 32'h0 : ref_word(t_addr[7:0]);
        end
        if (in_resp) begin
            if (t_mem) exp_mem_rdata = t_data; else exp_if_rdata = t_data;
        end

        check("if_gnt",     bus.if_gnt,     e_if_g);
        check("mem_gnt",    bus.mem_gnt,    e_mem_g);
        check("busy",       bus.busy,       cyc < free_at);
        check("m_re",       bus.m_re,       in_issue && !t_we && !t_mis);
        check("m_we",       bus.m_we,       in_issue && t_we && !t_mis);
        check("misalign",   bus.misalign,   in_issue && t_mis);
        check("if_rvalid",  bus.if_rvalid,  in_resp && !t_mem);
        check("mem_rvalid", bus.mem_rvalid, in_resp && t_mem);
        check("m_addr",     bus.m_addr,     exp_m_addr);
        check("if_rdata",   bus.if_rdata,   exp_if_rdata);
        check("mem_rdata",  bus.mem_rdata,  exp_mem_rdata);
        if (in_issue && t_we && !t_mis) check("m_wdata", bus.m_wdata, t_wdata);

        if (e_if_g || e_mem_g) begin
            txn_v      = 1'b1;
            tg         = cyc;
            t_mem      = e_mem_g;
            t_we       = e_mem_g && bus.mem_we;
            t_addr     = e_mem_g ? bus.mem_addr : bus.if_addr;
            t_wdata    = bus.mem_wdata;
            t_mis      = (t_addr[1:0] != 2'b00);
            free_at    = cyc + (t_we ? 2 : 4);
            last_mem   = e_mem_g;
            exp_m_addr = t_addr;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (e_if_g)  bus.if_req  = 1'b0;
        if (e_mem_g) bus.mem_req = 1'b0;
    endtask

    // Run until requests are accepted and the arbiter is free again.
    task automatic drain(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            cycle();
            done = !bus.if_req && !bus.mem_req && (cyc >= free_at);
        end
        check(tag, done, 1'b1);
    endtask

    task automatic do_if(input logic [31:0] addr);
        bus.if_req  = 1'b1;
        bus.if_addr = addr;
        drain("if_done");
    endtask

    task automatic do_mem(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        bus.mem_req   = 1'b1;
        bus.mem_we    = we;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        drain("mem_done");
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(0, 3));
        return a;
    endfunction

    // Random traffic: an idle requester raises a new request with p_* percent.
    task automatic run(input int n, input int p_if, input int p_mem);
        for (int i = 0; i < n; i++) begin
            if (!bus.if_req && ($urandom_range(0, 99) < p_if)) begin
                bus.if_req  = 1'b1;
                bus.if_addr = rand_addr();
            end
            if (!bus.mem_req && ($urandom_range(0, 99) < p_mem)) begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'($urandom_range(0, 1));
                bus.mem_addr  = rand_addr();
                bus.mem_wdata = $urandom;
            end
            cycle();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_if_gnt"},   bus.if_gnt,     1'b0);
        check({tag, "_mem_gnt"},  bus.mem_gnt,    1'b0);
        check({tag, "_m_re"},     bus.m_re,       1'b0);
        check({tag, "_m_we"},     bus.m_we,       1'b0);
        check({tag, "_misalign"}, bus.misalign,   1'b0);
        check({tag, "_busy"},     bus.busy,       1'b0);
        check({tag, "_if_rv"},    bus.if_rvalid,  1'b0);
        check({tag, "_mem_rv"},   bus.mem_rvalid, 1'b0);
        check({tag, "_m_addr"},   bus.m_addr,     32'h0);
        check({tag, "_if_rd"},    bus.if_rdata,   32'h0);
        check({tag, "_mem_rd"},   bus.mem_rdata,  32'h0);
    endtask

    initial begin
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i * 37 + 5);
            ref_mem[i] = 8'(i * 37 + 5);
        end
        mem[8'h10] = 8'hDE; mem[8'h11] = 8'hAD; mem[8'h12] = 8'hBE; mem[8'h13] = 8'hEF;
        ref_mem[8'h10] = 8'hDE; ref_mem[8'h11] = 8'hAD;
        ref_mem[8'h12] = 8'hBE; ref_mem[8'h13] = 8'hEF;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // IF read of a known word
        do_if(32'h10);
        check("t2_data", bus.if_rdata, 32'hDEADBEEF);

        // Store then load back; big-endian byte placement
        do_mem(1'b1, 32'h20, 32'h12345678);
        do_mem(1'b0, 32'h20, 32'h0);
        check("t3_load", bus.mem_rdata, 32'h12345678);
        check("t3_b0", {24'h0, mem[8'h20]}, 32'h12);
        check("t3_b1", {24'h0, mem[8'h21]}, 32'h34);
        check("t3_b2", {24'h0, mem[8'h22]}, 32'h56);
        check("t3_b3", {24'h0, mem[8'h23]}, 32'h78);

        // Misaligned load returns 0; misaligned store leaves memory alone
        do_mem(1'b0, 32'h22, 32'h0);
        check("t6_load", bus.mem_rdata, 32'h0);
        do_mem(1'b1, 32'h23, 32'hFFFFFFFF);
        check("t6_b3", {24'h0, mem[8'h23]}, 32'h78);
        check("t6_b4", {24'h0, mem[8'h24]}, {24'h0, 8'(8'h24 * 37 + 5)});

        // Both requesting continuously, then MEM backs off
        run(16, 100, 100);
        run(10, 100, 0);
        run(10, 0, 0);

        // Random traffic
        run(600, 35, 35);
        run(300, 80, 80);
        run(15, 0, 0);

        // Asynchronous reset in the ISSUE cycle of a store
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = 32'h40;
        bus.mem_wdata = 32'hA5C3_5A3C;
        for (int i = 0; i < 10 && bus.mem_req; i++) cycle();
        check("rst_pre_we", bus.m_we, 1'b1);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        txn_v = 1'b0; free_at = 0; last_mem = 1'b0;
        exp_if_rdata = '0; exp_mem_rdata = '0; exp_m_addr = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++)
            check("rst_nowrite", {24'h0, mem[8'h40 + 8'(k)]}, {24'h0, ref_mem[8'h40 + 8'(k)]});

        run(100, 50, 50);
        run(15, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
`default_nettype wire
